// File: rtl/issueque_int_if.sv
// Dispatch / CDB / issue bus bundle for the integer issue queue.
// The master drives dispatch, CDB and grant; the slave is the queue itself.
interface issueque_int_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 6
);
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            dispatch_en;
    logic [3:0]      dispatch_opcode;
    logic [31:0]     dispatch_rsdata;
    logic            dispatch_rsvalid;
    logic [TAGW-1:0] dispatch_rstag;
    logic [31:0]     dispatch_rtdata;
    logic            dispatch_rtvalid;
    logic [TAGW-1:0] dispatch_rttag;
    logic [TAGW-1:0] dispatch_rdtag;
    logic            cdb_valid;
    logic [TAGW-1:0] cdb_tagout;
    logic [31:0]     cdb_out;
    logic            issue_int;
    logic            ready_int;
    logic [3:0]      opcode;
    logic [31:0]     rsdata;
    logic [31:0]     rtdata;
    logic [TAGW-1:0] rdtag;
    logic            issueque_full;
    logic [CNTW-1:0] issueque_count;

    modport master (
        output flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid,
               dispatch_rstag, dispatch_rtdata, dispatch_rtvalid, dispatch_rttag,
               dispatch_rdtag, cdb_valid, cdb_tagout, cdb_out, issue_int,
        input  ready_int, opcode, rsdata, rtdata, rdtag, issueque_full, issueque_count
    );

    modport slave (
        input  flush, dispatch_en, dispatch_opcode, dispatch_rsdata, dispatch_rsvalid,
               dispatch_rstag, dispatch_rtdata, dispatch_rtvalid, dispatch_rttag,
               dispatch_rdtag, cdb_valid, cdb_tagout, cdb_out, issue_int,
        output ready_int, opcode, rsdata, rtdata, rdtag, issueque_full, issueque_count
    );
endinterface

// File: rtl/issueque_int.sv
// Age-ordered, compacting issue queue for the integer unit: entry 0 is oldest,
// the oldest entry with both operands captured is offered to the issue unit.
module issueque_int #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 6
) (
    input  logic          clk,
    input  logic          reset,
    issueque_int_if.slave q
);
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;
    localparam int unsigned IDXW = $clog2(DEPTH);

    typedef struct packed {
        logic            valid;
        logic [3:0]      opcode;
        logic [31:0]     rsdata;
        logic            rsvalid;
        logic [TAGW-1:0] rstag;
        logic [31:0]     rtdata;
        logic            rtvalid;
        logic [TAGW-1:0] rttag;
        logic [TAGW-1:0] rdtag;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    entry_t          ext   [DEPTH+1];
    entry_t          new_ent;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;
    logic [CNTW-1:0] wr_idx;
    logic [IDXW-1:0] sel_idx;
    logic            sel_found;
    logic            full;
    logic            do_issue;
    logic            do_disp;
    logic            rs_byp;
    logic            rt_byp;

    // Oldest ready entry wins: scan from the top so the lowest index lands last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].rsvalid && ent_q[i].rtvalid) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(i);
            end
        end
    end

    always_comb begin
        q.ready_int      = sel_found;
        q.opcode         = sel_found ? ent_q[sel_idx].opcode : 4'h0;
        q.rsdata         = sel_found ? ent_q[sel_idx].rsdata : 32'h0;
        q.rtdata         = sel_found ? ent_q[sel_idx].rtdata : 32'h0;
        q.rdtag          = sel_found ? ent_q[sel_idx].rdtag  : '0;
        q.issueque_full  = full;
        q.issueque_count = count_q;
    end

    assign full     = (count_q == CNTW'(DEPTH));
    assign do_issue = q.issue_int & sel_found;
    assign do_disp  = q.dispatch_en & ~full;
    assign wr_idx   = count_q - CNTW'(do_issue);
    assign count_d  = count_q + CNTW'(do_disp) - CNTW'(do_issue);
    assign rs_byp   = ~q.dispatch_rsvalid & q.cdb_valid & (q.cdb_tagout == q.dispatch_rstag);
    assign rt_byp   = ~q.dispatch_rtvalid & q.cdb_valid & (q.cdb_tagout == q.dispatch_rttag);

    // Incoming entry, with same-cycle CDB bypass on a missing operand.
    always_comb begin
        new_ent.valid   = 1'b1;
        new_ent.opcode  = q.dispatch_opcode;
        new_ent.rsvalid = q.dispatch_rsvalid | rs_byp;
        new_ent.rsdata  = rs_byp ? q.cdb_out : q.dispatch_rsdata;
        new_ent.rstag   = q.dispatch_rstag;
        new_ent.rtvalid = q.dispatch_rtvalid | rt_byp;
        new_ent.rtdata  = rt_byp ? q.cdb_out : q.dispatch_rtdata;
        new_ent.rttag   = q.dispatch_rttag;
        new_ent.rdtag   = q.dispatch_rdtag;
    end

    // Shift out the issued entry, wake operands in their new slots, then append.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ext[i] = ent_q[i];
        ext[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (do_issue && i >= int'(sel_idx)) ? ext[i+1] : ext[i];
            if (ent_d[i].valid && q.cdb_valid) begin
                if (!ent_d[i].rsvalid && ent_d[i].rstag == q.cdb_tagout) begin
                    ent_d[i].rsvalid = 1'b1;
                    ent_d[i].rsdata  = q.cdb_out;
                end
                if (!ent_d[i].rtvalid && ent_d[i].rttag == q.cdb_tagout) begin
                    ent_d[i].rtvalid = 1'b1;
                    ent_d[i].rtdata  = q.cdb_out;
                end
            end
            if (do_disp && int'(wr_idx) == i) ent_d[i] = new_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end
endmodule

// File: tb/tb_issueque_int.sv
// Directed bench for issueque_int: dispatch, wakeup, bypass, full/drop,
// out-of-order issue with compaction, flush and mid-stream reset.
module tb_issueque_int;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    issueque_int_if #(.DEPTH(4), .TAGW(6)) bus ();

    issueque_int #(.DEPTH(4), .TAGW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.flush            = 1'b0;
        bus.dispatch_en      = 1'b0;
        bus.dispatch_opcode  = 4'h0;
        bus.dispatch_rsdata  = 32'h0;
        bus.dispatch_rsvalid = 1'b0;
        bus.dispatch_rstag   = 6'd0;
        bus.dispatch_rtdata  = 32'h0;
        bus.dispatch_rtvalid = 1'b0;
        bus.dispatch_rttag   = 6'd0;
        bus.dispatch_rdtag   = 6'd0;
        bus.cdb_valid        = 1'b0;
        bus.cdb_tagout       = 6'd0;
        bus.cdb_out          = 32'h0;
        bus.issue_int        = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op,
                        input logic [31:0] rsd, input logic rsv, input logic [5:0] rst,
                        input logic [31:0] rtd, input logic rtv, input logic [5:0] rtt,
                        input logic [5:0] rd);
        bus.dispatch_en      = 1'b1;
        bus.dispatch_opcode  = op;
        bus.dispatch_rsdata  = rsd;
        bus.dispatch_rsvalid = rsv;
        bus.dispatch_rstag   = rst;
        bus.dispatch_rtdata  = rtd;
        bus.dispatch_rtvalid = rtv;
        bus.dispatch_rttag   = rtt;
        bus.dispatch_rdtag   = rd;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        bus.cdb_valid  = 1'b1;
        bus.cdb_tagout = tag;
        bus.cdb_out    = data;
    endtask

    // Advance one edge, settle, then return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ready", 32'(bus.ready_int), 32'd0);
        check("rst_count", 32'(bus.issueque_count), 32'd0);
        check("rst_full", 32'(bus.issueque_full), 32'd0);
        check("rst_opcode", 32'(bus.opcode), 32'd0);
        check("rst_rsdata", bus.rsdata, 32'd0);
        check("rst_rdtag", 32'(bus.rdtag), 32'd0);

        // Single fully-ready instruction, then issue it.
        disp(4'h1, 32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd3);
        tick();
        check("t1_ready", 32'(bus.ready_int), 32'd1);
        check("t1_opcode", 32'(bus.opcode), 32'h1);
        check("t1_rsdata", bus.rsdata, 32'd5);
        check("t1_rtdata", bus.rtdata, 32'd7);
        check("t1_rdtag", 32'(bus.rdtag), 32'd3);
        check("t1_count", 32'(bus.issueque_count), 32'd1);
        bus.issue_int = 1'b1;
        tick();
        check("t1_count_after", 32'(bus.issueque_count), 32'd0);
        check("t1_ready_after", 32'(bus.ready_int), 32'd0);

        // Younger ready B goes ahead of older waiting A; A wakes in its shifted slot.
        disp(4'h2, 32'h0, 1'b0, 6'd9, 32'd1, 1'b1, 6'd0, 6'd10);
        tick();
        check("t2_a_not_ready", 32'(bus.ready_int), 32'd0);
        disp(4'h3, 32'd11, 1'b1, 6'd0, 32'd22, 1'b1, 6'd0, 6'd11);
        tick();
        check("t2_b_first", 32'(bus.rdtag), 32'd11);
        check("t2_count", 32'(bus.issueque_count), 32'd2);
        cdb(6'd9, 32'hDEAD);
        bus.issue_int = 1'b1;
        tick();
        check("t2_a_rdtag", 32'(bus.rdtag), 32'd10);
        check("t2_a_rsdata", bus.rsdata, 32'hDEAD);
        check("t2_a_rtdata", bus.rtdata, 32'd1);
        check("t2_count_b", 32'(bus.issueque_count), 32'd1);
        bus.issue_int = 1'b1;
        tick();
        check("t2_empty", 32'(bus.issueque_count), 32'd0);

        // Fill, drop a 5th dispatch under simultaneous issue, then refill.
        for (int i = 0; i < 4; i++) begin
            disp(4'(i), 32'(100 + i), 1'b1, 6'd0, 32'(200 + i), 1'b1, 6'd0, 6'(20 + i));
            tick();
        end
        check("t3_full", 32'(bus.issueque_full), 32'd1);
        check("t3_count4", 32'(bus.issueque_count), 32'd4);
        check("t3_oldest", 32'(bus.rdtag), 32'd20);
        disp(4'h9, 32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd24);
        bus.issue_int = 1'b1;
        tick();
        check("t3_drop_count", 32'(bus.issueque_count), 32'd3);
        check("t3_drop_full", 32'(bus.issueque_full), 32'd0);
        disp(4'hA, 32'd300, 1'b1, 6'd0, 32'd301, 1'b1, 6'd0, 6'd25);
        tick();
        check("t3_refill_count", 32'(bus.issueque_count), 32'd4);
        check("t3_refill_full", 32'(bus.issueque_full), 32'd1);
        begin
            logic [5:0] order [4];
            order = '{6'd21, 6'd22, 6'd23, 6'd25};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("t3_order%0d", i), 32'(bus.rdtag), 32'(order[i]));
                bus.issue_int = 1'b1;
                tick();
            end
        end
        check("t3_drained", 32'(bus.issueque_count), 32'd0);

        // Same-cycle CDB bypass into a dispatched operand.
        disp(4'h5, 32'h0, 1'b0, 6'd12, 32'd3, 1'b1, 6'd0, 6'd30);
        cdb(6'd12, 32'h1234);
        tick();
        check("t4_ready", 32'(bus.ready_int), 32'd1);
        check("t4_rsdata", bus.rsdata, 32'h1234);
        check("t4_rtdata", bus.rtdata, 32'd3);
        bus.issue_int = 1'b1;
        tick();

        // Issue the middle entry while the youngest wakes in its new slot.
        disp(4'h6, 32'h0, 1'b0, 6'd1, 32'h40, 1'b1, 6'd0, 6'd40);
        tick();
        disp(4'h7, 32'h41, 1'b1, 6'd0, 32'h41, 1'b1, 6'd0, 6'd41);
        tick();
        disp(4'h8, 32'h42, 1'b1, 6'd0, 32'h0, 1'b0, 6'd7, 6'd42);
        tick();
        check("t5_mid_sel", 32'(bus.rdtag), 32'd41);
        cdb(6'd7, 32'h777);
        bus.issue_int = 1'b1;
        tick();
        check("t5_count", 32'(bus.issueque_count), 32'd2);
        check("t5_shift_rdtag", 32'(bus.rdtag), 32'd42);
        check("t5_shift_rtdata", bus.rtdata, 32'h777);
        check("t5_shift_rsdata", bus.rsdata, 32'h42);
        cdb(6'd63, 32'hBAD);
        tick();
        check("t5_nomatch_sel", 32'(bus.rdtag), 32'd42);
        cdb(6'd1, 32'h111);
        tick();
        check("t5_old_wins", 32'(bus.rdtag), 32'd40);
        check("t5_old_rsdata", bus.rsdata, 32'h111);
        cdb(6'd7, 32'h999);
        bus.issue_int = 1'b1;
        tick();
        check("t5_no_overwrite", bus.rtdata, 32'h777);
        check("t5_last_rdtag", 32'(bus.rdtag), 32'd42);

        // Both operands wake on one broadcast.
        disp(4'hB, 32'h0, 1'b0, 6'd5, 32'h0, 1'b0, 6'd5, 6'd50);
        tick();
        check("t6_count", 32'(bus.issueque_count), 32'd2);
        cdb(6'd5, 32'h55);
        bus.issue_int = 1'b1;
        tick();
        check("t6_rdtag", 32'(bus.rdtag), 32'd50);
        check("t6_rsdata", bus.rsdata, 32'h55);
        check("t6_rtdata", bus.rtdata, 32'h55);

        // Flush with a concurrent dispatch wins.
        disp(4'hC, 32'd1, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd51);
        tick();
        disp(4'hD, 32'd3, 1'b1, 6'd0, 32'd4, 1'b1, 6'd0, 6'd52);
        tick();
        check("t7_count3", 32'(bus.issueque_count), 32'd3);
        disp(4'hE, 32'd5, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 6'd53);
        bus.flush = 1'b1;
        tick();
        check("t7_count", 32'(bus.issueque_count), 32'd0);
        check("t7_ready", 32'(bus.ready_int), 32'd0);
        check("t7_opcode", 32'(bus.opcode), 32'd0);
        check("t7_rsdata", bus.rsdata, 32'd0);
        check("t7_rdtag", 32'(bus.rdtag), 32'd0);

        // Grant while empty must not underflow.
        bus.issue_int = 1'b1;
        tick();
        check("t8_empty_issue", 32'(bus.issueque_count), 32'd0);

        // Reset mid-stream discards everything, including a same-cycle dispatch.
        disp(4'h3, 32'd9, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 6'd60);
        tick();
        disp(4'h4, 32'd8, 1'b1, 6'd0, 32'd8, 1'b1, 6'd0, 6'd61);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t9_count", 32'(bus.issueque_count), 32'd0);
        check("t9_ready", 32'(bus.ready_int), 32'd0);
        check("t9_rtdata", bus.rtdata, 32'd0);
        check("t9_full", 32'(bus.issueque_full), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/issueque_int.md
# issueque_int

Four-entry, age-ordered issue queue (reservation station) for the integer execution unit. It sits between dispatch and the issue unit:
- Accepts decoded instructions from dispatch.
- Captures source operands by snooping the CDB.
- Presents the oldest fully-ready entry to the issue unit through the `ready_int`/`issue_int` handshake.
- Retires that entry when the issue unit grants it.

## Interface
Parameters:
- DEPTH, 4, number of entries (2..8); count width is clog2(DEPTH)+1
- TAGW, 6, ROB/rename tag width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- flush  in  1  clear all entries (mispredict recovery)
- dispatch_en  in  1  write a new entry this cycle
- dispatch_opcode  in  4  ALU opcode
- dispatch_rsdata  in  32  rs value, meaningful when dispatch_rsvalid=1
- dispatch_rsvalid  in  1  rs value present; else wait on dispatch_rstag
- dispatch_rstag  in  TAGW  rs producer tag
- dispatch_rtdata / dispatch_rtvalid / dispatch_rttag  in  32/1/TAGW  same for rt
- dispatch_rdtag  in  TAGW  destination tag
- cdb_valid  in  1  CDB broadcast valid
- cdb_tagout  in  TAGW  CDB tag
- cdb_out  in  32  CDB data
- issue_int  in  1  grant from issue unit; legal only while ready_int=1
- ready_int  out  1  an entry with both operands valid exists
- opcode  out  4  selected entry opcode
- rsdata, rtdata  out  32  selected entry operands
- rdtag  out  TAGW  selected entry destination tag
- issueque_full  out  1  count == DEPTH
- issueque_count  out  clog2(DEPTH)+1  valid entries

## Operation
- Storage: entries 0..DEPTH-1, compacted; entry 0 is oldest, valid entries are contiguous from 0.
- Per-entry fields: valid, opcode, rsdata, rsvalid, rstag, rtdata, rtvalid, rttag, rdtag.
- Select: lowest-index entry with valid & rsvalid & rtvalid. `ready_int`=1 iff one exists.
  - opcode/rsdata/rtdata/rdtag are driven combinationally from the selected entry.
  - When no entry is selected they are all-zero.
- Issue: on `issue_int`=1 the selected entry is removed and all higher entries shift down one place; order is preserved.
  - `issue_int` while `ready_int`=0 is ignored.
- Dispatch: when `dispatch_en`=1 and `issueque_full`=0, write to index count (or count-1 when issuing the same cycle).
  - `dispatch_en` while full is dropped; dispatch must stall on full. A same-cycle issue does not un-full the queue.
- Wakeup: for every valid entry whose operand has valid=0, if `cdb_valid` and `cdb_tagout`==tag, capture `cdb_out` and set valid=1.
  - Wakeup applies to entries in their post-shift position.
  - rs and rt of one entry may wake on the same broadcast.
- Dispatch bypass: if a dispatched operand has valid=0 and its tag matches the same-cycle CDB broadcast, it is written with valid=1 and data=`cdb_out`.
- Flush: all valid bits cleared and count=0 at the edge. Flush has priority over dispatch, issue and wakeup in the same cycle.
- Tags not matching any entry are ignored. A valid operand is never overwritten by CDB.

## Timing
- Reset (cycle after reset high at an edge): all entries invalid.
  - ready_int=0, opcode/rsdata/rtdata/rdtag=0, issueque_full=0, issueque_count=0.
  - Reset mid-operation discards all contents; reset has priority over flush.
- Dispatch of fully-valid operands at edge N: `ready_int`=1 during cycle N+1 (1-cycle dispatch-to-ready latency).
- CDB wakeup at edge N: entry selectable in cycle N+1. No combinational CDB-to-`ready_int` path.
- `ready_int` and issue outputs are combinational from registered state only. `issue_int` affects state at the next edge only.
- issueque_count update per edge: +1 on accepted dispatch, -1 on issue, unchanged on both.
- Back-to-back issue every cycle is supported while ready entries remain.

## Test plan
- Reset, then dispatch opcode 4'h1, rs=32'd5, rt=32'd7 (both valid), rdtag=6'd3.
  - Next cycle: ready_int=1, rsdata=5, rtdata=7, rdtag=3, count=1.
  - Assert issue_int: count returns to 0 and ready_int=0.
- Dispatch A (rs waits on tag 9) then B (all valid): B is selected first.
  - Then broadcast cdb_tagout=9, cdb_out=32'hDEAD.
  - After B issues, A is selected next cycle with rsdata=32'hDEAD.
- Fill 4 entries: issueque_full=1.
  - A 5th dispatch plus simultaneous issue: 5th is dropped, count becomes 3.
  - Next-cycle dispatch is accepted, count=4.
- Dispatch rs waiting on tag 12 in the same cycle as CDB tag 12 data 32'h1234 (bypass).
  - Entry ready next cycle with rsdata=32'h1234.
- Entries 0..2 waiting; issue entry 1 while CDB wakes entry 2's rt in the same cycle.
  - Old entry 2 moves to index 1 with rt captured; order preserved.
- With 3 entries, assert flush together with dispatch_en.
  - Next cycle: count=0, ready_int=0, outputs zero.
  - Separately, reset mid-stream yields the same state.
